lfsr_step_controller: RTL and testbench

LFSR_STEP_CONTROLLER -- requirements
Module: lfsr_step_controller

---
 rtl/lfsr_step_controller.sv | 146 ++++++++++++++
 tb/tb_lfsr_step_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_step_controller.sv
// Step/load pulse controller for an LFSR: debounces two push-buttons, runs a
// MANUAL/AUTO mode FSM with an auto-step period counter, and counts shifts.
module lfsr_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD_W        = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_step,
    input  logic                btn_mode,
    input  logic                seed_load,
    input  logic [PERIOD_W-1:0] period,
    output logic                shift_en,
    output logic                load_en,
    output logic                mode_auto,
    output logic [15:0]         step_count
);

    localparam int unsigned     DbW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StManual = 1'b0,
        StAuto   = 1'b1
    } state_e;

    // Bit 0 = step button, bit 1 = mode button.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          db_lvl_q, db_lvl_d;
    logic [1:0]          db_dly_q, db_dly_d;
    logic [1:0]          press_q, press_d;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0] period_lim;
    logic                shift_q, shift_d;
    logic                load_q, load_d;
    logic [15:0]         count_q, count_d;
    logic                step_req;

    // Synchronize, debounce and edge-detect both buttons.
    always_comb begin
        sync1_d  = {btn_mode, btn_step};
        sync2_d  = sync1_q;
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == db_lvl_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DbMax) begin
                db_cnt_d[b] = '0;
                db_lvl_d[b] = sync2_q[b];
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
            end
        end
        db_dly_d = db_lvl_q;
        // Rising debounced level only; releases are ignored.
        press_d  = db_lvl_q & ~db_dly_q;
    end

    // Mode FSM, period counter, load priority and step counting.
    always_comb begin
        period_lim = (period == '0) ? '0 : period - PERIOD_W'(1);
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        step_req   = 1'b0;

        // Step decision uses the old state even when the mode toggles now.
        unique case (state_q)
            StManual: begin
                step_req  = press_q[0];
                per_cnt_d = '0;
            end
            StAuto: begin
                if (per_cnt_q == period_lim) begin
                    step_req  = 1'b1;
                    per_cnt_d = '0;
                end else if (per_cnt_q > period_lim) begin
                    // Period lowered below the count: wrap without stepping.
                    per_cnt_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + PERIOD_W'(1);
                end
            end
        endcase

        if (press_q[1]) begin
            state_d   = (state_q == StManual) ? StAuto : StManual;
            per_cnt_d = '0;
        end

        load_d = seed_load;
        // A load drops (does not defer) any coincident step.
        if (seed_load) begin
            step_req  = 1'b0;
            per_cnt_d = '0;
        end
        shift_d = step_req;

        if (seed_load) begin
            count_d = '0;
        end else if (step_req) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_cnt_q  <= '0;
            db_lvl_q  <= '0;
            db_dly_q  <= '0;
            press_q   <= '0;
            state_q   <= StManual;
            per_cnt_q <= '0;
            shift_q   <= 1'b0;
            load_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_dly_q  <= db_dly_d;
            press_q   <= press_d;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            count_q   <= count_d;
        end
    end

    assign shift_en   = shift_q;
    assign load_en    = load_q;
    assign mode_auto  = (state_q == StAuto);
    assign step_count = count_q;

endmodule

// File: tb/tb_lfsr_step_controller.sv
// Scoreboard bench for lfsr_step_controller: stimulus pushes expected
// shift/load events (kind, cycle, step_count); a monitor pops and compares.
module tb_lfsr_step_controller;

    localparam int unsigned DB = 16;
    localparam int unsigned PW = 24;

    localparam logic [1:0] KShift = 2'b01;
    localparam logic [1:0] KLoad  = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_step;
    logic          btn_mode;
    logic          seed_load;
    logic [PW-1:0] period;
    logic          shift_en;
    logic          load_en;
    logic          mode_auto;
    logic [15:0]   step_count;

    typedef struct {
        logic [1:0]  kind;
        int unsigned cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt;

    lfsr_step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .PERIOD_W       (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_mode  (btn_mode),
        .seed_load (seed_load),
        .period    (period),
        .shift_en  (shift_en),
        .load_en   (load_en),
        .mode_auto (mode_auto),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Posedge counter; after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input int unsigned c, input logic [15:0] n);
        exp_t x;
        x.kind = k;
        x.cyc  = c;
        x.cnt  = n;
        sb_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Period-1 auto stepping: one shift expected on every following edge.
    task automatic auto_steps(input int n);
        for (int i = 0; i < n; i++) begin
            exp_cnt = exp_cnt + 16'd1;
            push(KShift, cyc + 1, exp_cnt);
            tick(1);
        end
    endtask

    // Monitor: compare every presented shift/load pulse with the queue head.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_event: kind %b due at cycle %0d, not observed by cycle %0d",
                     e.kind, e.cyc, cyc);
        end
        if (shift_en || load_en) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: kind %b at cycle %0d, none expected",
                         {load_en, shift_en}, cyc);
            end else begin
                e = sb_q.pop_front();
                if ({load_en, shift_en} !== e.kind || cyc != e.cyc || step_count !== e.cnt) begin
                    n_errors++;
                    $display("FAIL event: got kind %b cycle %0d count %0d, expected kind %b cycle %0d count %0d",
                             {load_en, shift_en}, cyc, step_count, e.kind, e.cyc, e.cnt);
                end
            end
        end
    end

    int unsigned r0;

    initial begin
        rst       = 1'b1;
        btn_step  = 1'b0;
        btn_mode  = 1'b0;
        seed_load = 1'b0;
        period    = PW'(4);
        exp_cnt   = '0;

        // Reset state.
        tick(3);
        check("rst_shift_en", {31'd0, shift_en}, 32'd0);
        check("rst_load_en", {31'd0, load_en}, 32'd0);
        check("rst_mode_auto", {31'd0, mode_auto}, 32'd0);
        check("rst_step_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Manual press held: one shift DB+3 edges after first sampling edge.
        r0 = cyc;
        btn_step = 1'b1;
        exp_cnt  = 16'd1;
        push(KShift, r0 + DB + 4, exp_cnt);
        tick(120);
        btn_step = 1'b0;
        tick(25);
        check("manual_count", {16'd0, step_count}, 32'd1);

        // Seed load clears the count.
        r0 = cyc;
        seed_load = 1'b1;
        exp_cnt   = '0;
        push(KLoad, r0 + 1, exp_cnt);
        tick(1);
        seed_load = 1'b0;
        tick(3);

        // Bouncing button: toggles every 5 cycles never settle.
        for (int i = 0; i < 40; i++) begin
            btn_step = ~btn_step;
            tick(5);
        end
        btn_step = 1'b0;
        tick(30);
        check("glitch_count", {16'd0, step_count}, 32'd0);
        check("glitch_mode", {31'd0, mode_auto}, 32'd0);

        // Mode press -> AUTO, period 4; step presses ignored.
        r0 = cyc;
        btn_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push(KShift, r0 + DB + 4 + 4 * k, exp_cnt + 16'(k));
        end
        exp_cnt = exp_cnt + 16'd10;
        tick(25);
        btn_mode = 1'b0;
        btn_step = 1'b1;
        tick(25);
        btn_step = 1'b0;
        tick(10);
        check("auto_mode", {31'd0, mode_auto}, 32'd1);
        check("auto_count10", {16'd0, step_count}, 32'd10);

        // Period 0 behaves as 1: a shift every cycle.
        period = '0;
        auto_steps(5);

        // Load beats the coincident step; next shift one cycle later.
        seed_load = 1'b1;
        exp_cnt   = '0;
        push(KLoad, cyc + 1, exp_cnt);
        tick(1);
        seed_load = 1'b0;
        check("load_count", {16'd0, step_count}, 32'd0);

        // 65536 steps: count climbs to 16'hFFFF and wraps to 0.
        auto_steps(65536);
        check("wrap_count", {16'd0, step_count}, 32'd0);

        // Reset in AUTO mid-period with btn_step held.
        period   = PW'(4);
        btn_step = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("rst2_shift_en", {31'd0, shift_en}, 32'd0);
        check("rst2_load_en", {31'd0, load_en}, 32'd0);
        check("rst2_mode_auto", {31'd0, mode_auto}, 32'd0);
        check("rst2_step_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        exp_cnt = 16'd1;
        push(KShift, cyc + DB + 4, exp_cnt);
        tick(45);
        btn_step = 1'b0;
        tick(30);
        check("final_count", {16'd0, step_count}, 32'd1);
        check("final_mode", {31'd0, mode_auto}, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
